// File: rtl/min_max_array_feeder.sv
// Feeder for the 16-entry min/max finder: loads a block from a valid/ready
// stream, kicks the finder, checks its answer against a running reference.
//
// Ports:
//   Clk, Reset                 clock, async active-high reset
//   In_Data/In_Valid/In_Ready  input byte stream
//   Rd_Addr/Rd_Data            combinational array read port for the finder
//   Start                      one-cycle kick to the finder
//   Fnd_Done/Fnd_Max/Fnd_Min   finder status and results
//   Res_Max/Res_Min/Res_Valid  captured result, held until Res_Ack
//   Res_Ack                    result consumed
//   Mismatch                   finder result differs from the reference
//   Err                        finder timed out
//   Busy                       not idle
module min_max_array_feeder #(
    parameter int N_WORDS = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           In_Data,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [$clog2(N_WORDS)-1:0] Rd_Addr,
    output logic [WIDTH-1:0]           Rd_Data,
    output logic                       Start,
    input  logic                       Fnd_Done,
    input  logic [WIDTH-1:0]           Fnd_Max,
    input  logic [WIDTH-1:0]           Fnd_Min,
    output logic [WIDTH-1:0]           Res_Max,
    output logic [WIDTH-1:0]           Res_Min,
    output logic                       Res_Valid,
    input  logic                       Res_Ack,
    output logic                       Mismatch,
    output logic                       Err,
    output logic                       Busy
);

    localparam int AW = $clog2(N_WORDS);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FILL  = 5'b00010,
        S_START = 5'b00100,
        S_WAIT  = 5'b01000,
        S_HOLD  = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [TW-1:0]     tc_q, tc_d;
    logic [WIDTH-1:0]  ref_max_q, ref_max_d;
    logic [WIDTH-1:0]  ref_min_q, ref_min_d;
    logic [WIDTH-1:0]  res_max_q, res_max_d;
    logic [WIDTH-1:0]  res_min_q, res_min_d;
    logic              res_valid_q, res_valid_d;
    logic              mismatch_q, mismatch_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              in_ready;
    logic              start;

    logic [WIDTH-1:0]  mem_q [N_WORDS];

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        tc_d        = tc_q;
        ref_max_d   = ref_max_q;
        ref_min_d   = ref_min_q;
        res_max_d   = res_max_q;
        res_min_d   = res_min_q;
        res_valid_d = res_valid_q;
        mismatch_d  = mismatch_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        in_ready    = 1'b0;
        start       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (In_Valid) begin
                    wr_en      = 1'b1;
                    ref_max_d  = In_Data;
                    ref_min_d  = In_Data;
                    wp_d       = AW'(1);
                    mismatch_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (In_Valid) begin
                    wr_en = 1'b1;
                    if (In_Data > ref_max_q) ref_max_d = In_Data;
                    if (In_Data < ref_min_q) ref_min_d = In_Data;
                    // pointer wraps to 0 naturally on the last beat
                    wp_d = wp_q + AW'(1);
                    if (wp_q == AW'(N_WORDS - 1)) state_d = S_START;
                end
            end
            S_START: begin
                start   = 1'b1;
                tc_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tc_d = tc_q + TW'(1);
                if (Fnd_Done) begin
                    res_max_d   = Fnd_Max;
                    res_min_d   = Fnd_Min;
                    mismatch_d  = (Fnd_Max != ref_max_q) ||
                                  (Fnd_Min != ref_min_q);
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (tc_q == TW'(TIMEOUT - 1)) begin
                    // finder gave up on us: report the reference instead
                    res_max_d   = ref_max_q;
                    res_min_d   = ref_min_q;
                    err_d       = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Res_Ack) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            wp_q        <= '0;
            tc_q        <= '0;
            ref_max_q   <= '0;
            ref_min_q   <= '0;
            res_max_q   <= '0;
            res_min_q   <= '0;
            res_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            tc_q        <= tc_d;
            ref_max_q   <= ref_max_d;
            ref_min_q   <= ref_min_d;
            res_max_q   <= res_max_d;
            res_min_q   <= res_min_d;
            res_valid_q <= res_valid_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
        end
    end

    // array contents are intentionally not reset
    always_ff @(posedge Clk) begin
        if (wr_en) mem_q[wp_q] <= In_Data;
    end

    assign Rd_Data   = mem_q[Rd_Addr];
    assign In_Ready  = in_ready;
    assign Start     = start;
    assign Res_Max   = res_max_q;
    assign Res_Min   = res_min_q;
    assign Res_Valid = res_valid_q;
    assign Mismatch  = mismatch_q;
    assign Err       = err_q;
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_min_max_array_feeder.sv
// Directed + randomized bench for min_max_array_feeder, with a simple
// finder model that scans the array through the read port.
module tb_min_max_array_feeder;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int TO = 64;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] In_Data;
    logic         In_Valid;
    logic         In_Ready;
    logic [3:0]   Rd_Addr;
    logic [W-1:0] Rd_Data;
    logic         Start;
    logic         Fnd_Done;
    logic [W-1:0] Fnd_Max;
    logic [W-1:0] Fnd_Min;
    logic [W-1:0] Res_Max;
    logic [W-1:0] Res_Min;
    logic         Res_Valid;
    logic         Res_Ack;
    logic         Mismatch;
    logic         Err;
    logic         Busy;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] blk [N];

    min_max_array_feeder #(.N_WORDS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Start(Start),
        .Fnd_Done(Fnd_Done), .Fnd_Max(Fnd_Max), .Fnd_Min(Fnd_Min),
        .Res_Max(Res_Max), .Res_Min(Res_Min), .Res_Valid(Res_Valid),
        .Res_Ack(Res_Ack), .Mismatch(Mismatch), .Err(Err), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] blk_max();
        int m = 0;
        for (int i = 0; i < N; i++) if (int'(blk[i]) > m) m = int'(blk[i]);
        return W'(m);
    endfunction

    function automatic logic [W-1:0] blk_min();
        int m = 255;
        for (int i = 0; i < N; i++) if (int'(blk[i]) < m) m = int'(blk[i]);
        return W'(m);
    endfunction

    // gap: 0 none, 1 every other cycle, 2 random
    task automatic send_block(input int gap, input int first);
        for (int i = first; i < N; i++) begin
            @(negedge Clk);
            In_Valid = 1'b1;
            In_Data  = blk[i];
            chk("in_ready_fill", 32'(In_Ready), 1);
            @(posedge Clk);
            if (i == 0) begin
                #1;
                chk("err_clr", 32'(Err), 0);
                chk("mism_clr", 32'(Mismatch), 0);
            end
            if (i < N - 1 && (gap == 1 ||
                (gap == 2 && $urandom_range(0, 1) == 1))) begin
                @(negedge Clk);
                In_Valid = 1'b0;
                In_Data  = W'($urandom);
                chk("in_ready_stall", 32'(In_Ready), 1);
                chk("start_early", 32'(Start), 0);
                @(posedge Clk);
            end
        end
        @(negedge Clk);
        In_Valid = 1'b0;
        chk("start_pulse", 32'(Start), 1);
        chk("in_ready_start", 32'(In_Ready), 0);
    endtask

    // finder model: scans all addresses, then reports (max - dmax, min)
    task automatic finder(input int dmax);
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        mx = blk_max();
        mn = blk_min();
        for (int a = 0; a < N; a++) begin
            @(negedge Clk);
            if (a == 0) chk("start_once", 32'(Start), 0);
            Rd_Addr = 4'(a);
            #1;
            chk("rd_data", 32'(Rd_Data), 32'(blk[a]));
        end
        @(negedge Clk);
        Fnd_Max  = mx - W'(dmax);
        Fnd_Min  = mn;
        Fnd_Done = 1'b1;
        @(negedge Clk);
        Fnd_Done = 1'b0;
        chk("res_valid", 32'(Res_Valid), 1);
        chk("res_max", 32'(Res_Max), 32'(mx - W'(dmax)));
        chk("res_min", 32'(Res_Min), 32'(mn));
        chk("mismatch", 32'(Mismatch), 32'(dmax != 0));
        chk("err_ok", 32'(Err), 0);
    endtask

    task automatic ack(input logic exp_mism, input logic exp_err);
        @(negedge Clk);
        Res_Ack = 1'b1;
        @(negedge Clk);
        Res_Ack = 1'b0;
        chk("ack_valid", 32'(Res_Valid), 0);
        chk("ack_busy", 32'(Busy), 0);
        chk("ack_mism_hold", 32'(Mismatch), 32'(exp_mism));
        chk("ack_err_hold", 32'(Err), 32'(exp_err));
    endtask

    initial begin
        int cnt;
        logic [W-1:0] hmx;
        int p;
        int q;
        Reset = 1'b1; In_Data = '0; In_Valid = 1'b0; Rd_Addr = '0;
        Fnd_Done = 1'b0; Fnd_Max = '0; Fnd_Min = '0; Res_Ack = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_valid", 32'(Res_Valid), 0);
        chk("rst_start", 32'(Start), 0);
        chk("rst_max", 32'(Res_Max), 0);
        chk("rst_min", 32'(Res_Min), 0);
        chk("rst_mism", 32'(Mismatch), 0);
        chk("rst_err", 32'(Err), 0);
        Reset = 1'b0;

        // stray Fnd_Done / Res_Ack in IDLE do nothing
        @(negedge Clk);
        Fnd_Done = 1'b1; Res_Ack = 1'b1;
        @(negedge Clk);
        Fnd_Done = 1'b0; Res_Ack = 1'b0;
        chk("idle_ign_valid", 32'(Res_Valid), 0);
        chk("idle_ign_busy", 32'(Busy), 0);

        // 1: ascending ramp then a small minimum
        for (int i = 0; i < N - 1; i++) blk[i] = W'((i + 1) * 16);
        blk[N-1] = 8'h05;
        send_block(0, 0);
        finder(0);
        ack(1'b0, 1'b0);

        // 2: all equal, In_Valid toggling
        for (int i = 0; i < N; i++) blk[i] = 8'h7F;
        send_block(1, 0);
        finder(0);
        ack(1'b0, 1'b0);

        // 3: finder under-reports the maximum
        for (int i = 0; i < N; i++) blk[i] = W'($urandom_range(1, 254));
        p = $urandom_range(0, N - 1);
        q = (p + 1 + $urandom_range(0, N - 2)) % N;
        blk[p] = 8'hFF;
        blk[q] = 8'h00;
        send_block(2, 0);
        finder(1);
        ack(1'b1, 1'b0);

        // 4: finder never answers
        for (int i = 0; i < N; i++) blk[i] = W'($urandom);
        send_block(0, 0);
        cnt = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge Clk);
            cnt = c;
            if (Err) break;
        end
        // WAIT is entered one edge after the Start negedge
        chk("err_latency", 32'(cnt), TO + 1);
        chk("to_valid", 32'(Res_Valid), 1);
        chk("to_max", 32'(Res_Max), 32'(blk_max()));
        chk("to_min", 32'(Res_Min), 32'(blk_min()));
        chk("to_mism", 32'(Mismatch), 0);
        ack(1'b0, 1'b1);

        // 5: reset in the middle of a fill
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            In_Valid = 1'b1;
            In_Data  = 8'hEE;
        end
        @(negedge Clk);
        Reset = 1'b1;
        In_Valid = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_err", 32'(Err), 0);
        chk("mid_rst_max", 32'(Res_Max), 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < N; i++) blk[i] = W'($urandom_range(0, 200));
        send_block(2, 0);
        finder(0);

        // 6: long hold with In_Valid high, then immediate restart
        hmx = Res_Max;
        for (int i = 0; i < N; i++) blk[i] = W'($urandom);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            In_Valid = 1'b1;
            In_Data  = 8'hAA;
            chk("hold_ready", 32'(In_Ready), 0);
            chk("hold_valid", 32'(Res_Valid), 1);
            chk("hold_max", 32'(Res_Max), 32'(hmx));
        end
        @(negedge Clk);
        Res_Ack = 1'b1;
        @(negedge Clk);
        Res_Ack = 1'b0;
        In_Data = blk[0];
        chk("restart_ready", 32'(In_Ready), 1);
        chk("restart_idle", 32'(Busy), 0);
        @(posedge Clk);
        #1;
        chk("restart_accept", 32'(Busy), 1);
        send_block(0, 1);
        finder(0);
        ack(1'b0, 1'b0);

        // a few random blocks
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) blk[i] = W'($urandom);
            send_block(2, 0);
            finder(0);
            ack(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/min_max_array_feeder.md
Name: min_max_array_feeder

Overview:
- Producer/consumer partner of the 16-entry unsigned min/max finder.
- Accepts N_WORDS bytes over a valid/ready stream and stores them in a register array. Serves that array to the finder through a combinational read port indexed by the finder's I.
- Pulses Start, waits for the finder's done state, then captures Max/Min and presents them on a valid/ack result handshake.
- Computes a reference min/max on the fly while filling and flags any disagreement or finder timeout.

Parameters:
- N_WORDS, 16, array depth; must be a power of 2, ≥2.
- WIDTH, 8, element width, unsigned.
- TIMEOUT, 64, maximum cycles in WAIT before Err is set.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- In_Data  input  WIDTH  stream data.
- In_Valid  input  1  stream data valid.
- In_Ready  output  1  feeder can accept In_Data.
- Rd_Addr  input  log2(N_WORDS)  finder read index (its I).
- Rd_Data  output  WIDTH  M[Rd_Addr], combinational.
- Start  output  1  one-cycle pulse to the finder.
- Fnd_Done  input  1  finder in DONE state (its Qd).
- Fnd_Max  input  WIDTH  finder Max.
- Fnd_Min  input  WIDTH  finder Min.
- Res_Max  output  WIDTH  captured maximum.
- Res_Min  output  WIDTH  captured minimum.
- Res_Valid  output  1  result available.
- Res_Ack  input  1  result consumed.
- Mismatch  output  1  captured result differs from the internal reference.
- Err  output  1  finder timeout.
- Busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - State IDLE; write pointer Wp=0; timeout counter Tc=0.
  - Start, Res_Valid, Mismatch, Err, Busy all 0.
  - Res_Max and Res_Min 0.
  - Array contents are not reset.
  - Reset mid-operation aborts everything immediately; any partially filled data is discarded logically.
- State machine: one-hot, states IDLE, FILL, START, WAIT, HOLD.
- IDLE:
  - In_Ready=1.
  - On In_Valid: write M[0]=In_Data, set RefMax=RefMin=In_Data, Wp←1, go to FILL.
  - Mismatch and Err are cleared on this same edge.
- FILL:
  - In_Ready=1.
  - Each accepted beat (In_Valid & In_Ready) writes M[Wp], Wp←Wp+1.
  - RefMax←max(RefMax,In_Data), RefMin←min(RefMin,In_Data).
  - Compare is unsigned, full WIDTH, ties keep the value (equal values give the same result).
  - When the beat with Wp==N_WORDS-1 is accepted: Wp wraps to 0, go to START.
  - In_Valid low stalls with no change.
- START:
  - In_Ready=0; Start=1 for exactly this one cycle.
  - Go to WAIT unconditionally; Tc←0.
- WAIT:
  - In_Ready=0, Start=0; Tc increments each cycle.
  - Fnd_Done=1: capture Res_Max←Fnd_Max and Res_Min←Fnd_Min.
    - Set Mismatch←(Fnd_Max≠RefMax)|(Fnd_Min≠RefMin).
    - Set Res_Valid←1, go to HOLD.
  - Else if Tc==TIMEOUT-1: set Err←1, Res_Valid←1 with Res_Max=RefMax and Res_Min=RefMin, go to HOLD.
  - If Fnd_Done and timeout occur in the same cycle, Fnd_Done wins.
- HOLD:
  - In_Ready=0; Res_Valid held at 1 and results stable until Res_Ack.
  - On Res_Ack: Res_Valid←0, go to IDLE.
  - Mismatch and Err persist until the next accepted first beat.
- Array timing:
  - The array is written only in IDLE/FILL and is read-only during START/WAIT, so the finder sees stable data.
  - Rd_Data is a pure mux with zero latency.
- Throughput:
  - The minimum load is N_WORDS cycles.
  - Result appears finder-latency+2 cycles after the last beat.
  - Back-to-back blocks are possible: a Res_Ack cycle is followed by IDLE accepting on the next cycle.
- Res_Ack outside HOLD is ignored. Fnd_Done outside WAIT is ignored.

Test Plan:
1. Reset, then stream 0x10,0x20,…,0xF0,0x05 (16 beats, In_Valid held high), with the finder model returning max 0xF0 / min 0x05. Expect:
   - Start pulses once, 1 cycle after the last beat.
   - Res_Valid with Res_Max=0xF0, Res_Min=0x05; Mismatch=0, Err=0.
   - Rd_Data matches M[Rd_Addr] for all 16 addresses.
2. All 16 beats equal to 0x7F, with In_Valid toggling every other cycle. Expect:
   - Fill completes after 31 cycles.
   - Res_Max=Res_Min=0x7F; RefMax=RefMin, so Mismatch=0.
3. Finder model returns Max=0xFE when the true maximum is 0xFF (data includes 0xFF and 0x00). Expect Mismatch=1, Res_Max=0xFE, Res_Min=0x00.
4. Fnd_Done is never asserted. Expect:
   - Err=1 exactly TIMEOUT cycles after entering WAIT.
   - Res_Max/Res_Min equal the reference values.
   - Res_Ack returns the block to IDLE, and the next first beat clears Err.
5. Assert Reset after 7 beats. Expect:
   - Outputs take reset values immediately.
   - A fresh 16-beat stream then produces correct results, unaffected by the stale entries.
6. Hold Res_Ack low for 10 cycles in HOLD while In_Valid=1. Expect:
   - In_Ready=0 throughout and results stable.
   - On the Res_Ack cycle the block goes to IDLE; the next beat is accepted the following cycle.
